// File: rtl/count_seq_checker.sv
// Monitors a qualified W-bit counter stream, locks onto up/down direction and
// flags every sample that breaks the sequence, keeping a saturating error count.
module count_seq_checker #(
  parameter int unsigned W   = 3,
  parameter int unsigned ECW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           in_valid,
  input  logic [W-1:0]   count_in,
  output logic           locked,
  output logic           dir,
  output logic [W-1:0]   expected,
  output logic           err,
  output logic [ECW-1:0] err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRST,
    S_LOCK
  } state_t;

  localparam logic [W-1:0] ONE = W'(1);

  state_t         state_q, state_d;
  logic [W-1:0]   prev_q, prev_d;
  logic           locked_q, locked_d;
  logic           dir_q, dir_d;
  logic [W-1:0]   expected_q, expected_d;
  logic           err_q, err_d;
  logic [ECW-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    locked_d   = locked_q;
    dir_d      = dir_q;
    expected_d = expected_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;

    if (clear) begin
      // clear beats a coincident sample: the sample is dropped
      state_d    = S_IDLE;
      prev_d     = '0;
      locked_d   = 1'b0;
      dir_d      = 1'b0;
      expected_d = '0;
      err_cnt_d  = '0;
    end else if (in_valid) begin
      unique case (state_q)
        S_IDLE: begin
          prev_d  = count_in;
          state_d = S_FIRST;
        end
        S_FIRST: begin
          if (count_in == prev_q + ONE) begin
            dir_d      = 1'b1;
            locked_d   = 1'b1;
            expected_d = count_in + ONE;
            state_d    = S_LOCK;
          end else if (count_in == prev_q - ONE) begin
            dir_d      = 1'b0;
            locked_d   = 1'b1;
            expected_d = count_in - ONE;
            state_d    = S_LOCK;
          end else begin
            prev_d = count_in;
          end
        end
        S_LOCK: begin
          if (count_in == expected_q) begin
            expected_d = dir_q ? expected_q + ONE : expected_q - ONE;
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            prev_d   = count_in;
            state_d  = S_FIRST;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + ECW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      prev_q     <= '0;
      locked_q   <= 1'b0;
      dir_q      <= 1'b0;
      expected_q <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      locked_q   <= locked_d;
      dir_q      <= dir_d;
      expected_q <= expected_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign locked   = locked_q;
  assign dir      = dir_q;
  assign expected = expected_q;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed-vector bench for count_seq_checker: default instance plus an
// ECW=2 instance sharing the same stimulus for the saturation case.
module tb_count_seq_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic [2:0] count_in;

  logic       locked, dir, err;
  logic [2:0] expected;
  logic [7:0] err_cnt;

  logic       locked2, dir2, err2;
  logic [2:0] expected2;
  logic [1:0] err_cnt2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  count_seq_checker #(.W(3), .ECW(8)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .count_in(count_in), .locked(locked), .dir(dir), .expected(expected),
    .err(err), .err_cnt(err_cnt)
  );

  count_seq_checker #(.W(3), .ECW(2)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .count_in(count_in), .locked(locked2), .dir(dir2), .expected(expected2),
    .err(err2), .err_cnt(err_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Apply one cycle of inputs; return 1 time unit after the sampling edge.
  task automatic step(input logic v, input logic [2:0] val, input logic c);
    in_valid = v;
    count_in = val;
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; count_in = '0;
    #3;
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_expected", expected, 0);
    chk("rst_dir", dir, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Up-lock with 7->0 wrap
    step(1, 3'd6, 0); chk("up_6_locked", locked, 0);
    step(1, 3'd7, 0); chk("up_7_locked", locked, 1);
    chk("up_7_dir", dir, 1); chk("up_7_exp", expected, 0);
    step(1, 3'd0, 0); chk("up_0_exp", expected, 1); chk("up_0_err", err, 0);
    step(1, 3'd1, 0); chk("up_1_exp", expected, 2); chk("up_1_err", err, 0);
    chk("up_err_cnt", err_cnt, 0);

    // Async reset between edges
    #1 reset = 1'b1;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_dir", dir, 0);
    chk("arst_expected", expected, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Down-lock, 0->7 wrap, violation, relock
    step(1, 3'd1, 0); chk("dn_1_locked", locked, 0);
    step(1, 3'd0, 0); chk("dn_0_locked", locked, 1);
    chk("dn_0_dir", dir, 0); chk("dn_0_exp", expected, 7);
    step(1, 3'd7, 0); chk("dn_7_exp", expected, 6); chk("dn_7_err", err, 0);
    step(1, 3'd5, 0); chk("dn_5_err", err, 1);
    chk("dn_5_cnt", err_cnt, 1); chk("dn_5_locked", locked, 0);
    step(1, 3'd4, 0); chk("dn_4_locked", locked, 1);
    chk("dn_4_dir", dir, 0); chk("dn_4_exp", expected, 3);
    chk("dn_4_err", err, 0); chk("dn_4_cnt", err_cnt, 1);

    // Stalls and repeats
    step(0, 3'd0, 1); chk("clr_cnt", err_cnt, 0); chk("clr_locked", locked, 0);
    step(1, 3'd2, 0); chk("st_2_locked", locked, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 3'd6, 0); chk("st_gap1_locked", locked, 0);
    end
    step(1, 3'd3, 0); chk("st_3_locked", locked, 1);
    chk("st_3_dir", dir, 1); chk("st_3_exp", expected, 4);
    for (int i = 0; i < 3; i++) begin
      step(0, 3'd7, 0); chk("st_gap2_exp", expected, 4); chk("st_gap2_err", err, 0);
    end
    step(1, 3'd3, 0); chk("rep_err", err, 1); chk("rep_cnt", err_cnt, 1);
    chk("rep_locked", locked, 0);
    step(1, 3'd5, 0); chk("f5_err", err, 0); chk("f5_locked", locked, 0);
    step(1, 3'd5, 0); chk("f55_err", err, 0); chk("f55_locked", locked, 0);
    step(1, 3'd2, 0); chk("f2_err", err, 0); chk("f2_locked", locked, 0);
    chk("f2_cnt", err_cnt, 1);

    // Build err_cnt = 3 while locked, then clear with a mismatching sample
    step(1, 3'd3, 0); chk("cp_lock1", locked, 1);
    step(1, 3'd0, 0); chk("cp_cnt2", err_cnt, 2);
    step(1, 3'd1, 0); chk("cp_lock2", locked, 1);
    step(1, 3'd7, 0); chk("cp_cnt3", err_cnt, 3);
    step(1, 3'd0, 0); chk("cp_lock3", locked, 1); chk("cp_exp", expected, 1);
    step(1, 3'd5, 1);
    chk("cp_clr_cnt", err_cnt, 0); chk("cp_clr_err", err, 0);
    chk("cp_clr_locked", locked, 0);
    // A stale lock would accept 1 here; from idle it only records it
    step(1, 3'd1, 0); chk("cp_idle_locked", locked, 0); chk("cp_idle_err", err, 0);
    step(1, 3'd2, 0); chk("cp_relock", locked, 1); chk("cp_relock_exp", expected, 3);

    // Saturation on the ECW=2 instance
    step(0, 3'd0, 1); chk("sat_clr", err_cnt2, 0);
    step(1, 3'd0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 3'd1, 0); chk("sat_lock", locked2, 1); chk("sat_noerr", err2, 0);
      step(1, 3'd0, 0); chk("sat_err", err2, 1);
      chk("sat_cnt", err_cnt2, (i + 1 > 3) ? 3 : i + 1);
    end
    chk("sat_wide_cnt", err_cnt, 5);
    step(0, 3'd0, 0); chk("sat_pulse_end", err2, 0); chk("sat_hold", err_cnt2, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Receive side of the 3-bit counter outputs.
- Samples a counter value stream qualified by `in_valid` and locks onto its direction: up (+1 mod 2^W) or down (−1 mod 2^W).
- Once locked, flags every sample that breaks the sequence and keeps a saturating error count.
- Sits downstream of the up/down counters as a self-check / monitor block.

Parameters:
- W, default 3: counter width. Must be ≥ 2, because for W = 1 the +1 and −1 steps are indistinguishable.
- ECW, default 8: error counter width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear of lock state and error count.
- in_valid  input  1  `count_in` is sampled on this clk edge.
- count_in  input  W  counter value under check.
- locked  output  1  direction acquired; checking active.
- dir  output  1  1 = up, 0 = down. Meaningful only while `locked` = 1.
- expected  output  W  next expected value. Meaningful only while `locked` = 1.
- err  output  1  one-cycle pulse on a sequence violation.
- err_cnt  output  ECW  saturating count of violations.

Behaviour:
- All outputs are registered. Everything updates on the rising clk edge that samples `in_valid`/`clear` and is visible the following cycle (latency 1).
- Async reset (`reset` = 1) values:
  - state = S_IDLE
  - `prev`, `locked`, `dir`, `expected`, `err`, `err_cnt` = 0
- Reset asserted mid-operation discards all state immediately, with no wait for clk.
- `err` is cleared every cycle it is not explicitly set (pulse only).
- Arithmetic is modulo 2^W: up of 2^W−1 is 0; down of 0 is 2^W−1.
- FSM (internal register `prev`, W bits):
  - S_IDLE:
    - `in_valid` → `prev` = `count_in`, go to S_FIRST.
    - No `in_valid` → hold.
  - S_FIRST (`locked` = 0):
    - `in_valid` and `count_in` == `prev`+1 → `dir` = 1, `locked` = 1, `expected` = `count_in`+1, go to S_LOCK.
    - `in_valid` and `count_in` == `prev`−1 → `dir` = 0, `locked` = 1, `expected` = `count_in`−1, go to S_LOCK.
    - `in_valid` with any other value (including equal to `prev`) → `prev` = `count_in`, stay. No `err`.
  - S_LOCK:
    - `in_valid` and `count_in` == `expected` → `expected` advances by ±1 per `dir`. `err` = 0.
    - `in_valid` and mismatch → `err` = 1; `err_cnt` += 1, saturating at 2^ECW−1; `locked` = 0; `prev` = `count_in`; go to S_FIRST.
    - A repeated value (no step) is a mismatch.
- `in_valid` = 0: no state change in any state. Gaps between samples are legal.
- `clear`:
  - Same as reset, except synchronous: state = S_IDLE, `locked` = 0, `err` = 0, `err_cnt` = 0.
  - `clear` with `in_valid` in the same cycle: `clear` wins and the sample is dropped.
- `err_cnt` at saturation: `err` still pulses, the count holds.

Test Plan:
- Reset: `reset` = 1 at any time → `locked`, `err`, `err_cnt`, `expected`, `dir` all 0 before the next clk edge.
- Up-lock, W = 3: feed 6, 7, 0, 1.
  - `locked` = 1 after 7, with `dir` = 1 and `expected` = 0.
  - Wrap 7→0 accepted; `expected` = 2 after 1.
  - `err` never asserted.
- Down-lock plus violation: feed 1, 0, 7, 5.
  - Lock on 0 with `dir` = 0; 0→7 wrap accepted.
  - 5 ≠ 6 → one-cycle `err`, `err_cnt` = 1, `locked` = 0.
  - Then feed 4 → relock with `dir` = 0, `expected` = 3.
- Stalls and repeats:
  - Feed 2, 3 with 3 idle cycles between them → lock; no change during the gaps.
  - Then feed 3 again → `err`, `err_cnt` increments.
  - In S_FIRST, feed 5, 5, 2 → no `err`, still unlocked.
- Clear priority: while locked with `err_cnt` = 3, assert `clear` together with `in_valid` and a mismatching value → next cycle `err_cnt` = 0, `err` = 0, state S_IDLE.
- Saturation, ECW = 2: force 5 violations → `err_cnt` holds at 3, and `err` pulses on all 5.
